// File: rtl/gcd_pkg.sv
// Shared types and mux encodings for the subtractive GCD datapath.
// The control unit and the datapath must agree on these select values.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } gcd_state_e;

    localparam logic SEL_IN       = 1'b0;
    localparam logic SEL_FWD      = 1'b1;
    localparam logic SEL_B_FROM_A = 1'b1;
    localparam logic FWD_SUB      = 1'b0;
    localparam logic FWD_B        = 1'b1;

endpackage

// File: rtl/gcd_regfile.sv
// A/B working registers with their input muxes, subtractor and comparator.
// Latency: one cycle per register update; status outputs are combinational from A/B.
// Backpressure: none; loads happen only when the parent asserts load or run.
module gcd_regfile
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             a_mux_sel,
    input  logic             a_reg_en,
    input  logic             b_mux_sel,
    input  logic             b_reg_en,
    input  logic             out_mux_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             b_zero,
    output logic             a_less
);

    logic [WIDTH-1:0] fwd;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;

    // The subtract result is only meaningful when A >= B; the control unit guarantees that.
    always_comb begin
        fwd   = (out_mux_sel == FWD_B) ? b_q : (a_q - b_q);
        a_nxt = (a_mux_sel == SEL_FWD) ? fwd : op_a;
        b_nxt = (b_mux_sel == SEL_B_FROM_A) ? a_q : op_b;
    end

    // Both next values are built from pre-edge A/B, so a swap is atomic.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= op_a;
            b_q <= op_b;
        end else if (run) begin
            if (a_reg_en) a_q <= a_nxt;
            if (b_reg_en) b_q <= b_nxt;
        end
    end

    assign b_zero = (b_q == '0);
    assign a_less = (a_q < b_q);

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: operand handshake, command execution on A/B, result handshake with iteration count and timeout.
// Latency: accept at cycle 0, LOAD cycle 1, RUN cycles 2..iter+2, out_valid_o from cycle iter+3.
// Backpressure: one job in flight; in_ready_o low until the result is taken, result held while out_ready_i is low.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_ITER = 1024,
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic              go_o,
    output logic              B_zero_o,
    output logic              A_less_o,
    input  logic              A_mux_sel_i,
    input  logic              A_reg_en_i,
    input  logic              B_mux_sel_i,
    input  logic              B_reg_en_i,
    input  logic              out_mux_sel_i,
    input  logic              done_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              err_o
);

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    gcd_state_e        state_q;
    logic [WIDTH-1:0]  op_a_q;
    logic [WIDTH-1:0]  op_b_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  result_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] iter_inc;
    logic              err_q;
    logic              in_ready_q;
    logic              go_q;
    logic              out_valid_q;
    logic              load_en;
    logic              run_en;

    assign iter_inc = iter_q + ITER_W'(1);

    // Control inputs only matter in RUN; outside it they may be X from an idle control unit.
    assign load_en = (state_q == LOAD);
    assign run_en  = (state_q == RUN) && !done_i;

    gcd_regfile #(
        .WIDTH(WIDTH)
    ) u_regfile (
        .clk         (clk_i),
        .rst         (rst_i),
        .load        (load_en),
        .run         (run_en),
        .a_mux_sel   (A_mux_sel_i),
        .a_reg_en    (A_reg_en_i),
        .b_mux_sel   (B_mux_sel_i),
        .b_reg_en    (B_reg_en_i),
        .out_mux_sel (out_mux_sel_i),
        .op_a        (op_a_q),
        .op_b        (op_b_q),
        .a_q         (a_q),
        .b_q         (b_q),
        .b_zero      (B_zero_o),
        .a_less      (A_less_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            go_q        <= 1'b0;
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            iter_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        op_a_q     <= a_i;
                        op_b_q     <= b_i;
                        in_ready_q <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    iter_q  <= '0;
                    go_q    <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    if (done_i) begin
                        result_q    <= a_q;
                        err_q       <= 1'b0;
                        go_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        iter_q <= iter_inc;
                        if (iter_inc == ITER_LIMIT) begin
                            result_q    <= '0;
                            err_q       <= 1'b1;
                            go_q        <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    go_q        <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign go_o        = go_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign iter_o      = iter_q;
    assign err_o       = err_q;

endmodule
